// File: rtl/tonegen_pkg.sv
// Shared types and helpers for the polyphonic tone generator.
package tonegen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } chan_state_t;

  // Number of clock cycles in one millisecond.
  function automatic int ms_div(input int fclk);
    return fclk / 1000;
  endfunction

endpackage

// File: rtl/tonegen_chan.sv
// One tone channel: phase accumulator square wave plus millisecond duration countdown.
module tonegen_chan
  import tonegen_pkg::*;
#(
  parameter int FCLK   = 50000000,
  parameter int FREQ_W = 32,
  parameter int DUR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic [FREQ_W-1:0] freq,
  input  logic [DUR_W-1:0]  dur_ms,
  output logic              spkr,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W = FREQ_W + 1;
  localparam logic [ACC_W-1:0] FCLK_V = ACC_W'(FCLK);
  localparam logic [ACC_W-1:0] HALF_V = ACC_W'(FCLK / 2);

  chan_state_t       state;
  logic [FREQ_W-1:0] freq_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  step;
  logic [DUR_W-1:0]  remaining;
  logic              expire;

  // Frequencies at or above Nyquist of the toggle rate saturate to a toggle every cycle.
  always_comb begin
    if (freq_q != '0 && {1'b0, freq_q} >= HALF_V) begin
      step = FCLK_V;
    end else begin
      step = {freq_q, 1'b0};
    end
  end

  assign expire = tick && (remaining == DUR_W'(1));
  assign busy   = (state == PLAY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      freq_q    <= '0;
      acc       <= '0;
      remaining <= '0;
      spkr      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PLAY;
            freq_q    <= freq;
            acc       <= '0;
            remaining <= dur_ms;
            spkr      <= 1'b0;
          end
        end
        PLAY: begin
          if (expire || stop) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            spkr      <= 1'b0;
            done      <= expire;
          end else begin
            // Keep the overshoot so the long-run toggle rate has no drift.
            if (acc >= FCLK_V - step) begin
              spkr <= ~spkr;
              acc  <= acc + step - FCLK_V;
            end else begin
              acc <= acc + step;
            end
            if (tick && remaining != '0) begin
              remaining <= remaining - DUR_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/tonegen_poly.sv
// Polyphonic tone generator: ms tick prescaler, command decode, NCHAN channels and XOR mixer.
module tonegen_poly
  import tonegen_pkg::*;
#(
  parameter int FCLK   = 50000000,
  parameter int NCHAN  = 4,
  parameter int FREQ_W = 32,
  parameter int DUR_W  = 16,
  localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CHAN_W-1:0] cmd_chan,
  input  logic              cmd_stop,
  input  logic [FREQ_W-1:0] cmd_freq,
  input  logic [DUR_W-1:0]  cmd_dur_ms,
  output logic [NCHAN-1:0]  spkr,
  output logic              spkr_mix,
  output logic [NCHAN-1:0]  busy,
  output logic [NCHAN-1:0]  done
);

  localparam int MS = ms_div(FCLK);
  localparam int TW = (MS > 1) ? $clog2(MS) : 1;

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic             in_range;
  logic             busy_sel;
  logic             accept;
  logic [NCHAN-1:0] start_v;
  logic [NCHAN-1:0] stop_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TW'(MS - 1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TW'(MS - 1));

  // Select busy of the addressed channel without indexing past NCHAN.
  always_comb begin
    in_range = ({1'b0, cmd_chan} < (CHAN_W + 1)'(NCHAN));
    busy_sel = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (CHAN_W'(i) == cmd_chan) begin
        busy_sel = busy[i];
      end
    end
  end

  always_comb begin
    if (reset) begin
      cmd_ready = 1'b0;
    end else if (cmd_stop || !in_range) begin
      cmd_ready = 1'b1;
    end else begin
      cmd_ready = ~busy_sel;
    end
  end

  assign accept = cmd_valid && cmd_ready && in_range;

  always_comb begin
    start_v = '0;
    stop_v  = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (accept && CHAN_W'(i) == cmd_chan) begin
        start_v[i] = ~cmd_stop;
        stop_v[i]  = cmd_stop;
      end
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    tonegen_chan #(
      .FCLK  (FCLK),
      .FREQ_W(FREQ_W),
      .DUR_W (DUR_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .start (start_v[g]),
      .stop  (stop_v[g]),
      .freq  (cmd_freq),
      .dur_ms(cmd_dur_ms),
      .spkr  (spkr[g]),
      .busy  (busy[g]),
      .done  (done[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spkr_mix <= 1'b0;
    end else begin
      spkr_mix <= ^spkr;
    end
  end

endmodule

// File: doc/tonegen_poly.md
TONEGEN_POLY -- requirements
Module: tonegen_poly

Interface
REQ-001 Parameter FCLK, default 50000000: clock frequency in Hz.
REQ-002 Parameter NCHAN, default 4: number of independent tone channels (1..16).
REQ-003 Parameter FREQ_W, default 32: width of the frequency field, in Hz.
REQ-004 Parameter DUR_W, default 16: width of the duration field, in ms.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1 bit: clock.
REQ-007 Port reset, input, 1 bit: synchronous active-high reset.
REQ-008 Port cmd_valid, input, 1 bit: a command is offered.
REQ-009 Port cmd_ready, output, 1 bit: the command is accepted on this cycle if cmd_valid is high.
REQ-010 Port cmd_chan, input, clog2(NCHAN) bits (minimum 1): target channel.
REQ-011 Port cmd_stop, input, 1 bit: 1 = stop the channel; 0 = start a note.
REQ-012 Port cmd_freq, input, FREQ_W bits: note frequency in Hz.
REQ-013 Port cmd_dur_ms, input, DUR_W bits: note duration in ms; 0 = play until stopped.
REQ-014 Port spkr, output, NCHAN bits: per-channel square wave.
REQ-015 Port spkr_mix, output, 1 bit: XOR of all bits of spkr.
REQ-016 Port busy, output, NCHAN bits: channel is in the PLAY state.
REQ-017 Port done, output, NCHAN bits: one-cycle pulse when a timed note expires.

Function
REQ-018 Handshake: cmd_ready SHALL be low while reset is high.
  - Otherwise, if cmd_stop = 1, cmd_ready SHALL be 1.
  - Otherwise, cmd_ready SHALL equal ~busy[cmd_chan].
  - cmd_chan >= NCHAN: cmd_ready = 1 and the command is dropped.
REQ-019 Each channel SHALL have two states: IDLE and PLAY.
  - IDLE->PLAY on an accepted start command.
  - PLAY->IDLE on an accepted stop command or on duration expiry.
REQ-020 Start command latency: the cycle after acceptance, busy = 1, the accumulator is 0, spkr = 0, and the remaining duration is cmd_dur_ms.
REQ-021 Tone generation in PLAY, with step = 2*freq:
  - Each cycle, acc <= acc + step.
  - If acc >= FCLK - step: spkr toggles and acc <= acc + step - FCLK (the remainder is kept, not zeroed).
  - The accumulator SHALL be FREQ_W+1 bits wide so the sum never wraps.
REQ-022 freq = 0: spkr SHALL stay 0 and no toggle occurs; the duration still counts down.
REQ-023 freq >= FCLK/2: the step SHALL be clamped to FCLK, giving a toggle on every cycle.
REQ-024 A shared ms tick SHALL pulse once every FCLK/1000 cycles.
  - The tick counter is free-running from reset release.
  - Duration accuracy is -1 ms / +0 ms.
REQ-025 Duration countdown: the remaining count decrements on each tick in PLAY while nonzero.
  - A tick with remaining = 1 SHALL, on the next cycle, give: IDLE, spkr = 0, busy = 0, and done = 1 for exactly one cycle.
REQ-026 Duration 0: the channel SHALL never expire and never pulse done.
REQ-027 Accepted stop: the next cycle SHALL give IDLE, spkr = 0, busy = 0, done = 0.
  - A stop to an IDLE channel has no effect.
REQ-028 Stop and expiry on the same cycle: the channel goes IDLE and done SHALL pulse.
REQ-029 Channels SHALL be fully independent; at most one command is accepted per cycle.
REQ-030 spkr_mix SHALL be registered, one cycle behind spkr.

Reset
REQ-031 When reset is high, on the clock edge:
  - all channels -> IDLE;
  - spkr, spkr_mix, busy and done -> 0;
  - accumulators, duration counters and the tick counter -> 0.
REQ-032 Reset asserted mid-note SHALL abort the note with no done pulse.

Structure
REQ-033 Package tonegen_pkg SHALL hold the channel state enum (IDLE, PLAY) and the function ms_div(FCLK) = FCLK/1000.
REQ-034 Sub-module tonegen_chan SHALL hold one channel: state, accumulator, duration counter, spkr and done.
  - It SHALL be instantiated NCHAN times in a generate loop.
  - The top SHALL hold the tick prescaler, command decode and mixer.

Verification
All scenarios use FCLK=10000 (ms tick every 10 cycles), NCHAN=4.
REQ-035 Start, ch0, freq=1000, dur=0 -> spkr[0] toggles every 5 cycles (10-cycle period), and busy[0] stays 1 for 200 cycles.
REQ-036 Start, ch1, freq=300, dur=0 -> spkr[1] toggles at cycle intervals of 17/17/16 (no cumulative drift), 600 toggles in 10000 cycles ±1.
REQ-037 Start, ch2, freq=500, dur=3 -> busy[2] stays high for 21-30 cycles, then done[2] pulses for exactly one cycle and spkr[2] = 0.
REQ-038 Start ch0, then a second start to ch0 while it is busy -> cmd_ready = 0 and the first note continues unchanged.
  - A stop to ch0 -> accepted; busy[0] = 0 next cycle; done[0] never pulses.
REQ-039 Start ch0 and ch1, both freq=1000, dur=0, issued on cycles 0 and 1 -> spkr_mix equals the XOR of spkr[0] and spkr[1], delayed one cycle.
REQ-040 Assert reset for one cycle while 4 channels play -> every output is 0 the next cycle, and no done pulse occurs.
